// File: rtl/scp_079.sv
// SCP-079 containment monitor: tracks operator neglect/response with a 6-bit countdown
// and escalates alarm levels up to a terminal breach; a three-button chord forces a timed safe state.
module scp_079 #(
    parameter int unsigned T_CONTAIN  = 35,
    parameter int unsigned T_RESPOND1 = 20,
    parameter int unsigned T_RESPOND2 = 10,
    parameter int unsigned T_NEGLECT  = 9,
    parameter int unsigned T_RECOVER  = 5,
    parameter int unsigned T_CHEAT    = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       green,
    input  logic       yellow,
    input  logic       red,
    output logic [2:0] state,
    output logic [5:0] timer,
    output logic       a1,
    output logic       a2,
    output logic       a3,
    output logic       cheat_out
);

    localparam logic [2:0] S_CONTAINED = 3'd0;
    localparam logic [2:0] S_RECOVER   = 3'd1;
    localparam logic [2:0] S_ALARM1    = 3'd2;
    localparam logic [2:0] S_ALARM2    = 3'd3;
    localparam logic [2:0] S_CHEAT     = 3'd4;
    localparam logic [2:0] S_BREACH    = 3'd5;

    localparam int unsigned NEG_W = ($clog2(T_NEGLECT + 1) > 4) ? $clog2(T_NEGLECT + 1) : 4;
    localparam logic [NEG_W-1:0] NEG_MAX = NEG_W'(T_NEGLECT);

    logic [2:0]       state_d, state_q;
    logic [5:0]       timer_d, timer_q;
    logic [NEG_W-1:0] neg_d, neg_q;

    logic in_cheat, in_red, in_yellow, in_green;
    logic       go;
    logic [2:0] go_s;
    logic       timer_last;

    // Input classes are mutually exclusive, resolved in priority order cheat > red > yellow > green.
    assign in_cheat  = green & yellow & red;
    assign in_red    = red & ~in_cheat;
    assign in_yellow = yellow & ~red;
    assign in_green  = green & ~yellow & ~red;

    assign timer_last = (timer_q == 6'd1);

    function automatic logic [5:0] entry_val(input logic [2:0] s);
        case (s)
            S_RECOVER: entry_val = 6'(T_RECOVER);
            S_ALARM1:  entry_val = 6'(T_RESPOND1);
            S_ALARM2:  entry_val = 6'(T_RESPOND2);
            S_CHEAT:   entry_val = 6'(T_CHEAT);
            S_BREACH:  entry_val = 6'd0;
            default:   entry_val = 6'(T_CONTAIN);
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        neg_d   = neg_q;
        go      = 1'b0;
        go_s    = state_q;

        if (in_cheat && state_q != S_BREACH && state_q != S_CHEAT && state_q <= S_BREACH) begin
            go   = 1'b1;
            go_s = S_CHEAT;
        end else begin
            case (state_q)
                S_CONTAINED: begin
                    if (in_green) begin
                        if (timer_last) begin
                            go   = 1'b1;
                            go_s = S_ALARM1;
                        end else begin
                            timer_d = timer_q - 6'd1;
                        end
                    end else begin
                        timer_d = 6'(T_CONTAIN);
                    end
                end
                S_ALARM1: begin
                    if (in_yellow) begin
                        neg_d = '0;
                        if (timer_last) begin
                            go   = 1'b1;
                            go_s = S_CONTAINED;
                        end else begin
                            timer_d = timer_q - 6'd1;
                        end
                    end else if (in_green) begin
                        if (neg_q >= NEG_MAX - 1'b1) begin
                            go   = 1'b1;
                            go_s = S_ALARM2;
                        end else begin
                            neg_d = neg_q + 1'b1;
                        end
                    end
                end
                S_ALARM2: begin
                    if (in_red) begin
                        neg_d = '0;
                        if (timer_last) begin
                            go   = 1'b1;
                            go_s = S_RECOVER;
                        end else begin
                            timer_d = timer_q - 6'd1;
                        end
                    end else if (in_green) begin
                        if (neg_q >= NEG_MAX - 1'b1) begin
                            go   = 1'b1;
                            go_s = S_BREACH;
                        end else begin
                            neg_d = neg_q + 1'b1;
                        end
                    end
                end
                S_RECOVER, S_CHEAT: begin
                    // Both run down unconditionally; a repeated chord in CHEAT does not restart it.
                    if (timer_last) begin
                        go   = 1'b1;
                        go_s = S_CONTAINED;
                    end else begin
                        timer_d = timer_q - 6'd1;
                    end
                end
                S_BREACH: begin
                    timer_d = 6'd0;
                end
                default: begin
                    go   = 1'b1;
                    go_s = S_CONTAINED;
                end
            endcase
        end

        if (go) begin
            state_d = go_s;
            timer_d = entry_val(go_s);
            neg_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_CONTAINED;
            timer_q <= 6'(T_CONTAIN);
            neg_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            neg_q   <= neg_d;
        end
    end

    assign state     = state_q;
    assign timer     = timer_q;
    assign a1        = (state_q == S_ALARM1) || (state_q == S_ALARM2) || (state_q == S_BREACH);
    assign a2        = (state_q == S_ALARM2) || (state_q == S_BREACH);
    assign a3        = (state_q == S_BREACH);
    assign cheat_out = (state_q == S_CHEAT);

endmodule

// File: tb/tb_scp_079.sv
// Bench for scp_079: directed game scenarios followed by randomized button play,
// every cycle compared against a behavioural model of the game rules.
module tb_scp_079;

    logic       clock = 1'b0;
    logic       reset, green, yellow, red;
    logic [2:0] state;
    logic [5:0] timer;
    logic       a1, a2, a3, cheat_out;

    int checks   = 0;
    int failures = 0;

    localparam int CONTAINED = 0, RECOVER = 1, ALARM1 = 2, ALARM2 = 3, CHEAT = 4, BREACH = 5;
    localparam int T_CONTAIN = 35, T_RESPOND1 = 20, T_RESPOND2 = 10;
    localparam int T_NEGLECT = 9, T_RECOVER = 5, T_CHEAT = 10;

    int m_state, m_timer, m_neglect;

    scp_079 dut (
        .clock(clock), .reset(reset), .green(green), .yellow(yellow), .red(red),
        .state(state), .timer(timer), .a1(a1), .a2(a2), .a3(a3), .cheat_out(cheat_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int entry_of(input int s);
        case (s)
            ALARM1:  return T_RESPOND1;
            ALARM2:  return T_RESPOND2;
            RECOVER: return T_RECOVER;
            CHEAT:   return T_CHEAT;
            BREACH:  return 0;
            default: return T_CONTAIN;
        endcase
    endfunction

    function automatic void enter(input int s);
        m_state   = s;
        m_timer   = entry_of(s);
        m_neglect = 0;
    endfunction

    // Count the timer down one step; the step that would reach zero moves to 'nxt' instead.
    function automatic void count_down(input int nxt);
        if (m_timer == 1) enter(nxt);
        else m_timer = m_timer - 1;
    endfunction

    function automatic void neglect(input int nxt);
        m_neglect = m_neglect + 1;
        if (m_neglect >= T_NEGLECT) enter(nxt);
    endfunction

    function automatic void model_step(input bit rst, input bit g, input bit y, input bit r);
        string cls;
        if (rst) begin
            enter(CONTAINED);
            return;
        end
        if (g && y && r) cls = "cheat";
        else if (r)      cls = "red";
        else if (y)      cls = "yellow";
        else if (g)      cls = "green";
        else             cls = "none";
        if (cls == "cheat" && m_state != BREACH && m_state != CHEAT) begin
            enter(CHEAT);
            return;
        end
        case (m_state)
            CONTAINED: if (cls == "green") count_down(ALARM1); else m_timer = T_CONTAIN;
            ALARM1: begin
                if (cls == "yellow") begin m_neglect = 0; count_down(CONTAINED); end
                else if (cls == "green") neglect(ALARM2);
            end
            ALARM2: begin
                if (cls == "red") begin m_neglect = 0; count_down(RECOVER); end
                else if (cls == "green") neglect(BREACH);
            end
            RECOVER, CHEAT: count_down(CONTAINED);
            default: m_timer = 0;
        endcase
    endfunction

    task automatic compare_model(input string where);
        check({where, ".state"}, 8'(state), 8'(m_state));
        check({where, ".timer"}, 8'(timer), 8'(m_timer));
        check({where, ".a1"}, 8'(a1), 8'(m_state == ALARM1 || m_state == ALARM2 || m_state == BREACH));
        check({where, ".a2"}, 8'(a2), 8'(m_state == ALARM2 || m_state == BREACH));
        check({where, ".a3"}, 8'(a3), 8'(m_state == BREACH));
        check({where, ".cheat_out"}, 8'(cheat_out), 8'(m_state == CHEAT));
    endtask

    task automatic step(input bit rst, input bit g, input bit y, input bit r, input string where);
        reset = rst; green = g; yellow = y; red = r;
        @(posedge clock);
        #1;
        model_step(rst, g, y, r);
        compare_model(where);
    endtask

    task automatic repeat_step(input int n, input bit g, input bit y, input bit r, input string where);
        for (int i = 0; i < n; i++) step(1'b0, g, y, r, where);
    endtask

    initial begin
        reset = 1'b1; green = 1'b0; yellow = 1'b0; red = 1'b0;
        m_state = CONTAINED; m_timer = T_CONTAIN; m_neglect = 0;
        #2;

        // Reset and first escalation
        step(1'b1, 0, 0, 0, "rst");
        step(1'b1, 1, 1, 1, "rst_wins");
        check("reset_state", 8'(state), 8'd0);
        check("reset_timer", 8'(timer), 8'd35);
        check("reset_alarms", 8'({a1, a2, a3, cheat_out}), 8'd0);
        repeat_step(34, 1, 0, 0, "green34");
        check("green34_state", 8'(state), 8'd0);
        check("green34_timer", 8'(timer), 8'd1);
        step(1'b0, 1, 0, 0, "green35");
        check("alarm1_state", 8'(state), 8'd2);
        check("alarm1_a1", 8'(a1), 8'd1);
        check("alarm1_timer", 8'(timer), 8'd20);

        // ALARM1 re-contained by yellow
        repeat_step(20, 0, 1, 0, "yellow20");
        check("recontain_state", 8'(state), 8'd0);
        check("recontain_a1", 8'(a1), 8'd0);
        check("recontain_timer", 8'(timer), 8'd35);

        // 19 yellow then NONE holds at timer 1
        repeat_step(35, 1, 0, 0, "to_alarm1");
        repeat_step(19, 0, 1, 0, "yellow19");
        step(1'b0, 0, 0, 0, "none_hold");
        check("hold_state", 8'(state), 8'd2);
        check("hold_timer", 8'(timer), 8'd1);

        // Neglect escalation to breach
        repeat_step(9, 1, 0, 0, "neglect1");
        check("alarm2_state", 8'(state), 8'd3);
        check("alarm2_a1a2", 8'({a1, a2}), 8'd3);
        repeat_step(9, 1, 0, 0, "neglect2");
        check("breach_state", 8'(state), 8'd5);
        check("breach_alarms", 8'({a1, a2, a3}), 8'd7);
        check("breach_timer", 8'(timer), 8'd0);
        step(1'b0, 1, 1, 1, "breach_cheat");
        step(1'b0, 0, 1, 0, "breach_yellow");
        step(1'b0, 0, 0, 1, "breach_red");
        check("breach_sticky", 8'(state), 8'd5);
        step(1'b1, 0, 0, 0, "breach_reset");
        check("post_breach_state", 8'(state), 8'd0);
        check("post_breach_timer", 8'(timer), 8'd35);

        // ALARM2 -> RECOVER -> CONTAINED
        repeat_step(35 + 9, 1, 0, 0, "to_alarm2");
        repeat_step(10, 0, 0, 1, "red10");
        check("recover_state", 8'(state), 8'd1);
        check("recover_timer", 8'(timer), 8'd5);
        for (int i = 0; i < 5; i++) begin
            logic [2:0] b;
            b = 3'($urandom_range(0, 6));
            step(1'b0, b[0], b[1], b[2], "recover_run");
        end
        check("recovered_state", 8'(state), 8'd0);
        check("recovered_timer", 8'(timer), 8'd35);

        // Cheat chord from CONTAINED with timer 10; repeated chord is ignored
        repeat_step(25, 1, 0, 0, "to_t10");
        check("t10_timer", 8'(timer), 8'd10);
        step(1'b0, 1, 1, 1, "cheat_in");
        check("cheat_state", 8'(state), 8'd4);
        check("cheat_out", 8'(cheat_out), 8'd1);
        check("cheat_timer", 8'(timer), 8'd10);
        repeat_step(3, 1, 1, 1, "cheat_again");
        repeat_step(7, 0, 0, 0, "cheat_run");
        check("cheat_done_state", 8'(state), 8'd0);
        check("cheat_done_out", 8'(cheat_out), 8'd0);

        // Non-green reload, then reset mid-ALARM2
        repeat_step(20, 1, 0, 0, "g20");
        step(1'b0, 0, 1, 0, "y1");
        repeat_step(34, 1, 0, 0, "g34");
        check("reload_state", 8'(state), 8'd0);
        check("reload_timer", 8'(timer), 8'd1);
        repeat_step(1 + 9, 1, 0, 0, "to_alarm2b");
        repeat_step(3, 0, 0, 1, "red3");
        check("mid_alarm2_state", 8'(state), 8'd3);
        step(1'b1, 1, 0, 0, "reset_mid");
        check("reset_mid_state", 8'(state), 8'd0);
        check("reset_mid_alarms", 8'({a1, a2, a3}), 8'd0);

        // Randomized play: hold a random button pattern for a random run length
        for (int seg = 0; seg < 400; seg++) begin
            int kind, len;
            bit g, y, r;
            kind = $urandom_range(0, 99);
            len  = $urandom_range(1, 40);
            g = 0; y = 0; r = 0;
            if (kind < 3)       begin g = 1; y = 1; r = 1; len = 1; end
            else if (kind < 40) g = 1;
            else if (kind < 60) y = 1;
            else if (kind < 75) r = 1;
            else if (kind < 90) begin g = 1'($urandom); y = 1'($urandom); r = 1'($urandom); end
            if (kind >= 97) step(1'b1, g, y, r, "rand_reset");
            else repeat_step(len, g, y, r, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scp_079.md
Name: scp_079

Overview:
- Containment-monitor FSM for the "SCP-079" game. An operator drives three pushbutton levels: green, yellow and red.
- The block tracks operator neglect and response with a 6-bit countdown timer, and escalates alarm levels a1, a2 and a3 up to a terminal breach.
- A cheat combination forces a timed safe state.
- It is a self-contained top-level game controller. Display and LED logic are outside this block.

Parameters:
- T_CONTAIN, 35, qualifying green cycles in CONTAINED before ALARM1.
- T_RESPOND1, 20, yellow cycles in ALARM1 needed to re-contain.
- T_RESPOND2, 10, red cycles in ALARM2 needed to reach RECOVER.
- T_NEGLECT, 9, green cycles of neglect in ALARM1/ALARM2 that escalate the alarm.
- T_RECOVER, 5, cycles spent in RECOVER.
- T_CHEAT, 10, cycles spent in CHEAT.

Ports:
- clock, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, synchronous, active-high.
- green, input, 1, green button level.
- yellow, input, 1, yellow button level.
- red, input, 1, red button level.
- state, output, 3, current FSM state encoding.
- timer, output, 6, current countdown value.
- a1, output, 1, alarm level 1.
- a2, output, 1, alarm level 2.
- a3, output, 1, alarm level 3 (breach).
- cheat_out, output, 1, high while in CHEAT.

Behaviour:
- One clock; reset is synchronous and active-high. Reset wins over all inputs.
- Reset values: state=0, timer=T_CONTAIN, internal neglect counter=0, a1=a2=a3=cheat_out=0.
- Input class is evaluated each rising edge, in priority order:
  - CHEAT = green&yellow&red
  - else RED = red
  - else YELLOW = yellow
  - else GREEN = green
  - else NONE
- State encodings: 0 CONTAINED, 1 RECOVER, 2 ALARM1, 3 ALARM2, 4 CHEAT, 5 BREACH. Codes 6 and 7 go to CONTAINED with timer=T_CONTAIN on the next edge.
- On entering any state, timer loads that state's entry value and the neglect counter clears.
- Entry values: CONTAINED=T_CONTAIN, ALARM1=T_RESPOND1, ALARM2=T_RESPOND2, RECOVER=T_RECOVER, CHEAT=T_CHEAT, BREACH=0.
- "Expires" means a decrement occurs while timer==1. On that edge the FSM transitions instead of writing 0. The timer therefore never shows 0 outside BREACH.
- CHEAT input in any state except BREACH or CHEAT: go to CHEAT on that edge. This has highest priority after reset.
- CONTAINED:
  - GREEN: timer decrements; on expiry go to ALARM1.
  - NONE, YELLOW or RED: timer reloads T_CONTAIN.
- ALARM1:
  - YELLOW: timer decrements; on expiry go to CONTAINED.
  - GREEN: neglect counter increments; when it reaches T_NEGLECT go to ALARM2.
  - NONE or RED: hold timer and neglect counter.
  - YELLOW also clears the neglect counter.
- ALARM2:
  - RED: timer decrements; on expiry go to RECOVER. RED also clears the neglect counter.
  - GREEN: neglect counter increments; when it reaches T_NEGLECT go to BREACH.
  - NONE or YELLOW: hold.
- RECOVER: timer decrements every cycle regardless of input; on expiry go to CONTAINED.
- CHEAT: timer decrements every cycle; on expiry go to CONTAINED. Further CHEAT input is ignored (no restart).
- BREACH: terminal; timer=0; exits only on reset.
- Outputs are Moore, decoded from the registered state:
  - a1=1 in ALARM1, ALARM2 and BREACH.
  - a2=1 in ALARM2 and BREACH.
  - a3=1 in BREACH only.
  - cheat_out=1 in CHEAT only.
- Timer is 6-bit unsigned. Parameters must be ≤63 and ≥1 (except the BREACH value of 0).
- Neglect counter is internal, 4 bits minimum. It saturates at T_NEGLECT.

Test Plan:
- Reset 2 cycles, then green=1 only for 34 cycles -> state=0, timer=1. One more green cycle -> state=2, a1=1, timer=20.
- In ALARM1, yellow=1 only for 20 cycles -> state=0, a1=0, timer=35. Separately, 19 yellow cycles then 1 NONE cycle -> stays state=2, timer=1.
- From ALARM1, green only for 9 cycles -> state=3, a1=a2=1. Green 9 more -> state=5, a1=a2=a3=1, timer=0. Green/yellow/red=1 afterwards -> stays 5 until reset, after which state=0, timer=35.
- In ALARM2, red=1 for 10 cycles -> state=1, timer=5. 5 more cycles with any input except CHEAT -> state=0, timer=35.
- In CONTAINED with timer=10, assert green+yellow+red for 1 cycle -> state=4, cheat_out=1, timer=10. After 10 cycles -> state=0, cheat_out=0.
- In CONTAINED, green 20 cycles, yellow 1 cycle, green 34 cycles -> state=0, timer=1 (reload confirmed). Assert reset mid-ALARM2 -> next edge state=0, all alarms 0.
